// File: rtl/prpg_3bit_lfsr.sv
// rtl/prpg_3bit_lfsr.sv - 3-bit maximal-length Fibonacci LFSR pattern generator
// Optional one-cycle period marker output `wrap` when PRPG_WRAP_FLAG_EN is defined.
module prpg_3bit_lfsr #(
  parameter logic [2:0] SEED     = 3'b001,
  parameter int         POLY_SEL = 0
) (
  input  logic       clk,
  input  logic       clr,
`ifdef PRPG_WRAP_FLAG_EN
  output logic       wrap,
`endif
  output logic [3:1] p_output
);

  // An all-zero seed would lock the LFSR, so it is replaced by 001.
  localparam logic [3:1] EFF_SEED = (SEED == 3'b000) ? 3'b001 : SEED;

  logic       feedback;
  logic [3:1] next_state;

  always_comb begin
    feedback = (POLY_SEL == 1) ? (p_output[3] ^ p_output[1])
                               : (p_output[3] ^ p_output[2]);
    next_state = {p_output[2], p_output[1], feedback};
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      p_output <= EFF_SEED;
    end else if (p_output == 3'b000) begin
      p_output <= EFF_SEED;
    end else begin
      p_output <= next_state;
    end
  end

`ifdef PRPG_WRAP_FLAG_EN
  // Only a genuine step back onto the seed marks a period boundary.
  always_ff @(posedge clk) begin
    if (clr || p_output == 3'b000) begin
      wrap <= 1'b0;
    end else begin
      wrap <= (next_state == EFF_SEED);
    end
  end
`endif

endmodule

// File: tb/tb_prpg_3bit_lfsr.sv
// tb/tb_prpg_3bit_lfsr.sv - directed self-checking bench for prpg_3bit_lfsr
`timescale 1ns/1ps
module tb_prpg_3bit_lfsr;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [3:1] p0, p1, ps6, ps0;
`ifdef PRPG_WRAP_FLAG_EN
  logic       w0, w1, ws6, ws0;
`endif

  int n_run  = 0;
  int n_fail = 0;

  logic [2:0] seq0 [7] = '{3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100, 3'b001};
  logic [2:0] seq1 [7] = '{3'b011, 3'b111, 3'b110, 3'b101, 3'b010, 3'b100, 3'b001};

  always #7.5 clk = ~clk;

  prpg_3bit_lfsr #(.SEED(3'b001), .POLY_SEL(0)) dut0 (
    .clk(clk), .clr(clr),
`ifdef PRPG_WRAP_FLAG_EN
    .wrap(w0),
`endif
    .p_output(p0));

  prpg_3bit_lfsr #(.SEED(3'b001), .POLY_SEL(1)) dut1 (
    .clk(clk), .clr(clr),
`ifdef PRPG_WRAP_FLAG_EN
    .wrap(w1),
`endif
    .p_output(p1));

  prpg_3bit_lfsr #(.SEED(3'b110), .POLY_SEL(0)) dut_s6 (
    .clk(clk), .clr(clr),
`ifdef PRPG_WRAP_FLAG_EN
    .wrap(ws6),
`endif
    .p_output(ps6));

  prpg_3bit_lfsr #(.SEED(3'b000), .POLY_SEL(0)) dut_s0 (
    .clk(clk), .clr(clr),
`ifdef PRPG_WRAP_FLAG_EN
    .wrap(ws0),
`endif
    .p_output(ps0));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_run++;
      if (p0 !== 3'b001) begin
        n_fail++;
        $display("FAIL reset_p0 edge %0d: got %b expected 001", i, p0);
      end
      n_run++;
      if (p1 !== 3'b001) begin
        n_fail++;
        $display("FAIL reset_p1 edge %0d: got %b expected 001", i, p1);
      end
    end
    clr = 1'b0;
  endtask

  task automatic test_seq_poly0();
    do_reset();
    for (int i = 0; i < 14; i++) begin
      tick();
      n_run++;
      if (p0 !== seq0[i % 7] || p0 === 3'b000) begin
        n_fail++;
        $display("FAIL seq_poly0 step %0d: got %b expected %b", i + 1, p0, seq0[i % 7]);
      end
    end
  endtask

  task automatic test_seq_poly1();
    do_reset();
    for (int i = 0; i < 14; i++) begin
      tick();
      n_run++;
      if (p1 !== seq1[i % 7] || p1 === 3'b000) begin
        n_fail++;
        $display("FAIL seq_poly1 step %0d: got %b expected %b", i + 1, p1, seq1[i % 7]);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    n_run++;
    if (p0 !== 3'b111) begin
      n_fail++;
      $display("FAIL mid_reset_pre: got %b expected 111", p0);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_run++;
    if (p0 !== 3'b001) begin
      n_fail++;
      $display("FAIL mid_reset_reload: got %b expected 001", p0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_run++;
      if (p0 !== seq0[i]) begin
        n_fail++;
        $display("FAIL mid_reset_resume step %0d: got %b expected %b", i + 1, p0, seq0[i]);
      end
    end
  endtask

  task automatic test_seed();
    clr = 1'b1;
    tick();
    n_run++;
    if (ps6 !== 3'b110) begin
      n_fail++;
      $display("FAIL seed110_reset: got %b expected 110", ps6);
    end
    n_run++;
    if (ps0 !== 3'b001) begin
      n_fail++;
      $display("FAIL seed000_reset: got %b expected 001", ps0);
    end
    clr = 1'b0;
    tick();
    n_run++;
    if (ps6 !== 3'b100) begin
      n_fail++;
      $display("FAIL seed110_step: got %b expected 100", ps6);
    end
    n_run++;
    if (ps0 !== 3'b010) begin
      n_fail++;
      $display("FAIL seed000_step: got %b expected 010", ps0);
    end
  endtask

  task automatic test_lockup();
    do_reset();
    tick();
    tick();
    @(negedge clk);
    force dut0.p_output = 3'b000;
    #1;
    release dut0.p_output;
    tick();
    n_run++;
    if (p0 !== 3'b001) begin
      n_fail++;
      $display("FAIL lockup_recover: got %b expected 001", p0);
    end
    for (int i = 0; i < 7; i++) begin
      tick();
      n_run++;
      if (p0 !== seq0[i]) begin
        n_fail++;
        $display("FAIL lockup_resume step %0d: got %b expected %b", i + 1, p0, seq0[i]);
      end
    end
  endtask

`ifdef PRPG_WRAP_FLAG_EN
  task automatic test_wrap();
    clr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_run++;
      if (w0 !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_in_reset edge %0d: got %b expected 0", i, w0);
      end
    end
    clr = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      n_run++;
      if (w0 !== ((i == 6 || i == 13) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL wrap step %0d: got %b expected %b", i + 1, w0, (i == 6 || i == 13));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_seq_poly0();
    test_seq_poly1();
    test_mid_reset();
    test_seed();
    test_lockup();
`ifdef PRPG_WRAP_FLAG_EN
    test_wrap();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
